fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the controller in the 19-bit CPU. It owns the PC and the IR and prefetches the instruction at PC from instruction memory over a req/ack handshake into a one-entry buffer. It presents opcode/IR to the controller and consumes the controller's loadIR, loadPC and incPC strobes.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/fetch_timeout_ctr.sv | 36 +++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths, fetch state encoding and opcodes of the 19-bit CPU
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int CPU_DATA_W  = 19;
    localparam int CPU_ADDR_W  = 19;
    localparam int CPU_OPC_W   = 5;
    localparam int CPU_OPC_MSB = CPU_DATA_W - 1;
    localparam int CPU_OPC_LSB = CPU_DATA_W - CPU_OPC_W;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [CPU_OPC_W-1:0] OP_NOP   = 5'd0;
    localparam logic [CPU_OPC_W-1:0] OP_LOAD  = 5'd1;
    localparam logic [CPU_OPC_W-1:0] OP_STORE = 5'd2;
    localparam logic [CPU_OPC_W-1:0] OP_ADD   = 5'd3;
    localparam logic [CPU_OPC_W-1:0] OP_SUB   = 5'd4;
    localparam logic [CPU_OPC_W-1:0] OP_AND   = 5'd5;
    localparam logic [CPU_OPC_W-1:0] OP_OR    = 5'd6;
    localparam logic [CPU_OPC_W-1:0] OP_JMP   = 5'd7;
    localparam logic [CPU_OPC_W-1:0] OP_BEQ   = 5'd8;
    localparam logic [CPU_OPC_W-1:0] OP_HALT  = 5'd31;

endpackage

`default_nettype wire

// File: rtl/fetch_timeout_ctr.sv
// ============================================================================
// fetch_timeout_ctr : saturating wait counter with clear; reached_o flags the
//                     increment that brings the count to LIMIT
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic reached_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign reached_o = inc_i && !clr_i && (cnt_q >= CW'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC/IR owner; prefetches the word at PC into a one-entry buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int OPC_W   = CPU_OPC_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              loadIR,
    input  logic              loadPC,
    input  logic              incPC,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [OPC_W-1:0]  opcode,
    output logic [ADDR_W-1:0] pc,
    output logic              buf_valid,
    output logic              stall,
    output logic              fetch_err
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] buf_q;
    logic              buf_valid_q;
    logic              req_q;
    logic              stall_q;
    logic              err_q;
    logic              discard_q;

    logic              w_pc_upd;
    logic [ADDR_W-1:0] w_pc_d;
    logic              w_in_req;
    logic              w_to_reached;

    assign w_pc_upd = loadPC || incPC;
    assign w_pc_d   = loadPC ? branch_addr : (pc_q + ADDR_W'(1));
    assign w_in_req = (state_q == FETCH_REQ);

    fetch_timeout_ctr #(
        .LIMIT     (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!w_in_req || imem_ack),
        .inc_i     (w_in_req && !imem_ack),
        .reached_o (w_to_reached)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= '0;
            addr_q      <= '0;
            ir_q        <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            req_q       <= 1'b0;
            stall_q     <= 1'b0;
            err_q       <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            stall_q <= loadIR && !buf_valid_q;
            if (loadIR && buf_valid_q) begin
                ir_q <= buf_q;
            end
            if (w_pc_upd) begin
                pc_q <= w_pc_d;
            end

            case (state_q)
                FETCH_IDLE: begin
                    if (w_pc_upd) begin
                        buf_valid_q <= 1'b0;
                    end else if (en && !err_q) begin
                        state_q <= FETCH_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                FETCH_REQ: begin
                    // A PC change while the read is outstanding makes its data stale.
                    if (imem_ack) begin
                        req_q     <= 1'b0;
                        discard_q <= 1'b0;
                        if (discard_q || w_pc_upd) begin
                            state_q <= FETCH_IDLE;
                        end else begin
                            buf_q       <= imem_rdata;
                            buf_valid_q <= 1'b1;
                            state_q     <= FETCH_HOLD;
                        end
                    end else if (w_to_reached) begin
                        err_q     <= 1'b1;
                        req_q     <= 1'b0;
                        discard_q <= 1'b0;
                        state_q   <= FETCH_IDLE;
                    end else if (w_pc_upd) begin
                        discard_q <= 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (w_pc_upd) begin
                        buf_valid_q <= 1'b0;
                        state_q     <= FETCH_IDLE;
                    end
                end
                default: begin
                    state_q <= FETCH_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[DATA_W-1 -: OPC_W];
    assign pc        = pc_q;
    assign buf_valid = buf_valid_q;
    assign stall     = stall_q;
    assign fetch_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed + randomized bench for fetch_unit with a
//                 transaction-level reference model and a memory responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int AW = 19;
    localparam int DW = 19;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          loadIR = 1'b0;
    logic          loadPC = 1'b0;
    logic          incPC = 1'b0;
    logic [AW-1:0] branch_addr = '0;
    logic          imem_ack = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] ir;
    logic [4:0]    opcode;
    logic [AW-1:0] pc;
    logic          buf_valid;
    logic          stall;
    logic          fetch_err;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .loadIR      (loadIR),
        .loadPC      (loadPC),
        .incPC       (incPC),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .opcode      (opcode),
        .pc          (pc),
        .buf_valid   (buf_valid),
        .stall       (stall),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: spec-level view of the fetch stage
    logic [AW-1:0] m_pc, m_addr;
    logic [DW-1:0] m_ir, m_buf;
    bit            m_req, m_bufv, m_stall, m_err, m_discard;
    int            m_wait;

    // Memory responder controls
    int lat = 2;
    bit dead = 1'b0;
    bit bad_data = 1'b0;
    bit spur_ack = 1'b0;
    bit rand_lat = 1'b0;

    function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
        logic [DW-1:0] t;
        t = a * 19'h01357;
        return t + 19'h0C123;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_addr = '0; m_ir = '0; m_buf = '0;
        m_req = 0; m_bufv = 0; m_stall = 0; m_err = 0; m_discard = 0; m_wait = 0;
    endtask

    task automatic check_outputs();
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", 32'(imem_addr), 32'(m_addr));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("ir", 32'(ir), 32'(m_ir));
        chk("opcode", 32'(opcode), 32'(m_ir[18:14]));
        chk("buf_valid", 32'(buf_valid), 32'(m_bufv));
        chk("stall", 32'(stall), 32'(m_stall));
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cycle(input bit l_ir, input bit l_pc, input bit i_pc, input bit e,
                         input logic [AW-1:0] ba);
        bit            ack;
        bit            upd;
        logic [DW-1:0] rd;
        logic [AW-1:0] npc;
        ack = m_req && !dead && (m_wait >= lat);
        rd  = bad_data ? 19'h7FFFF : memword(m_addr);
        if (spur_ack && !m_req) begin
            ack = 1'b1;
            rd  = 19'h7FFFF;
        end
        loadIR = l_ir; loadPC = l_pc; incPC = i_pc; en = e; branch_addr = ba;
        imem_ack = ack; imem_rdata = rd;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        upd     = l_pc || i_pc;
        npc     = l_pc ? ba : m_pc + 19'd1;
        m_stall = l_ir && !m_bufv;
        if (l_ir && m_bufv) m_ir = m_buf;
        if (m_req) begin
            if (ack) begin
                if (!m_discard && !upd) begin
                    m_bufv = 1;
                    m_buf  = rd;
                end
                m_req = 0; m_discard = 0; m_wait = 0;
            end else if (m_wait + 1 == TO) begin
                m_err = 1; m_req = 0; m_discard = 0; m_wait = 0;
            end else begin
                m_wait++;
                if (upd) m_discard = 1;
            end
        end else if (upd) begin
            m_bufv = 0;
        end else if (!m_bufv && e && !m_err) begin
            m_req  = 1;
            m_addr = m_pc;
            m_wait = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end
        if (upd) m_pc = npc;
        #1;
    endtask

    task automatic wait_req(input int budget);
        for (int i = 0; i < budget && !m_req; i++) cycle(0, 0, 0, 1, '0);
        chk("wait_req", 32'(imem_req), 32'd1);
    endtask

    task automatic wait_hold(input int budget);
        for (int i = 0; i < budget && !m_bufv; i++) cycle(0, 0, 0, 1, '0);
        chk("wait_hold", 32'(buf_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        loadIR = 0; loadPC = 0; incPC = 0; en = 0; imem_ack = 0; branch_addr = '0;
        model_reset();
        @(posedge clk); #1;
        check_outputs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // loadIR with an empty buffer right after reset
        cycle(1, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, '0);

        // First fetch, ack two cycles after request, then the normal fetch cycle
        lat = 2;
        wait_req(5);
        chk("first_addr", 32'(imem_addr), 32'd0);
        wait_hold(20);
        cycle(1, 0, 1, 1, '0);
        chk("first_ir", 32'(ir), 32'h0C123);
        chk("first_opcode", 32'(opcode), 32'b00011);
        chk("first_pc", 32'(pc), 32'd1);
        wait_req(5);
        chk("addr_after_inc", 32'(imem_addr), 32'd1);
        wait_hold(20);

        // loadPC beats incPC
        cycle(0, 1, 0, 1, 19'd4);
        wait_hold(20);
        cycle(0, 1, 1, 1, 19'h00100);
        chk("branch_pc", 32'(pc), 32'h00100);
        wait_req(5);
        chk("branch_addr", 32'(imem_addr), 32'h00100);
        wait_hold(20);

        // PC change during outstanding read: stale data must be dropped
        cycle(0, 1, 0, 1, 19'd7);
        wait_req(5);
        chk("req7_addr", 32'(imem_addr), 32'd7);
        lat = 4;
        bad_data = 1'b1;
        cycle(0, 1, 0, 1, 19'h00020);
        for (int i = 0; i < 10 && m_req; i++) cycle(0, 0, 0, 1, '0);
        bad_data = 1'b0;
        chk("discard_empty", 32'(buf_valid), 32'd0);
        wait_req(5);
        chk("refetch_addr", 32'(imem_addr), 32'h00020);
        wait_hold(20);
        cycle(1, 0, 0, 1, '0);
        chk("refetch_ir", 32'(ir), 32'(memword(19'h00020)));

        // PC wrap
        lat = 1;
        cycle(0, 1, 0, 1, 19'h7FFFF);
        wait_hold(20);
        cycle(0, 0, 1, 1, '0);
        chk("wrap_pc", 32'(pc), 32'd0);
        wait_req(5);
        chk("wrap_addr", 32'(imem_addr), 32'd0);
        wait_hold(20);

        // Memory never acks
        cycle(0, 1, 0, 1, 19'h00033);
        dead = 1'b1;
        wait_req(5);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, '0);
        chk("timeout_err", 32'(fetch_err), 32'd1);
        chk("timeout_req", 32'(imem_req), 32'd0);
        cycle(0, 0, 1, 1, '0);
        cycle(1, 1, 0, 1, 19'h00040);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, '0);
        dead = 1'b0;
        do_reset();
        chk("err_cleared", 32'(fetch_err), 32'd0);

        // Reset in the middle of a request, then a late ack
        lat = 5;
        wait_req(5);
        #3 rst_n = 1'b0;
        #1 chk("req_async_drop", 32'(imem_req), 32'd0);
        model_reset();
        imem_ack = 1'b1; imem_rdata = 19'h7FFFF; en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        spur_ack = 1'b1;
        cycle(0, 0, 0, 0, '0);
        spur_ack = 1'b0;
        cycle(0, 0, 0, 0, '0);
        chk("late_ack_ignored", 32'(buf_valid), 32'd0);

        // Randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            spur_ack = ($urandom_range(0, 9) == 0);
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                  AW'($urandom));
        end
        spur_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
